lsu_dmem_if: RTL

Load/store unit sitting in the MEM stage, consuming the decoder's `mem_read`, `mem_write`, `mem_load_type` and `mem_store_type` and carrying out the access on the data-memory request/response bus. Stores get byte-lane steering and byte enables; loads get lane extraction and sign/zero extension. It checks alignment, times out hung responses, and holds the pipeline with `lsu_stall` until each access completes.

---
 rtl/lsu_dmem_if_if.sv | 34 +++
 rtl/lsu_dmem_if.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_dmem_if_if.sv
// Data-memory request/response bus between the load/store unit
// and the memory (or its arbiter).
interface lsu_dmem_if_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_gnt;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req,
      output dmem_we,
      output dmem_addr,
      output dmem_be,
      output dmem_wdata,
      input  dmem_gnt,
      input  dmem_rvalid,
      input  dmem_rdata
   );

   modport slave (
      input  dmem_req,
      input  dmem_we,
      input  dmem_addr,
      input  dmem_be,
      input  dmem_wdata,
      output dmem_gnt,
      output dmem_rvalid,
      output dmem_rdata
   );
endinterface

// File: rtl/lsu_dmem_if.sv
// MEM-stage load/store unit: lane steering, extension, alignment
// check and response timeout on the data-memory bus.
module lsu_dmem_if #(
   parameter int RSP_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  mem_load_type,
   input  logic [1:0]  mem_store_type,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] load_data,
   output logic        lsu_stall,
   output logic        lsu_done,
   output logic        lsu_misalign,
   output logic        lsu_bus_err,
   lsu_dmem_if_if.master dmem
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT_RSP,
      DONE
   } state_t;

   localparam int CW = $clog2(RSP_TIMEOUT) + 1;
   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   state_t state, state_n;

   logic          access;
   logic [1:0]    sz;
   logic          uns;
   logic          misal;
   logic [3:0]    be_st;
   logic [31:0]   wd_st;

   logic [1:0]    off_q;
   logic [1:0]    sz_q;
   logic          uns_q;
   logic          ld_q;
   logic [CW-1:0] cnt;
   logic          tmo;

   logic [7:0]    rbyte;
   logic [15:0]   rhalf;
   logic [31:0]   rext;

   assign access = mem_read | mem_write;

   // A store takes priority; its read request is dropped.
   always_comb begin
      sz  = SZ_W;
      uns = 1'b0;
      if (mem_write) begin
         unique case (mem_store_type)
            2'b00:   sz = SZ_B;
            2'b01:   sz = SZ_H;
            default: sz = SZ_W;
         endcase
      end else begin
         unique case (mem_load_type)
            3'b000:  sz = SZ_B;
            3'b001:  sz = SZ_H;
            3'b011: begin
               sz  = SZ_B;
               uns = 1'b1;
            end
            3'b100: begin
               sz  = SZ_H;
               uns = 1'b1;
            end
            default: sz = SZ_W;
         endcase
      end
   end

   assign misal = ((sz == SZ_H) & mem_addr[0])
                | ((sz == SZ_W) & (|mem_addr[1:0]));

   always_comb begin
      be_st = 4'b1111;
      wd_st = '0;
      if (mem_write) begin
         unique case (sz)
            SZ_B: begin
               be_st = 4'b0001 << mem_addr[1:0];
               wd_st = {4{mem_wdata[7:0]}};
            end
            SZ_H: begin
               be_st = mem_addr[1] ? 4'b1100 : 4'b0011;
               wd_st = {2{mem_wdata[15:0]}};
            end
            default: begin
               be_st = 4'b1111;
               wd_st = mem_wdata;
            end
         endcase
      end
   end

   always_comb begin
      rbyte = '0;
      unique case (off_q)
         2'd0:    rbyte = dmem.dmem_rdata[7:0];
         2'd1:    rbyte = dmem.dmem_rdata[15:8];
         2'd2:    rbyte = dmem.dmem_rdata[23:16];
         default: rbyte = dmem.dmem_rdata[31:24];
      endcase
   end

   assign rhalf = off_q[1] ? dmem.dmem_rdata[31:16]
                           : dmem.dmem_rdata[15:0];

   always_comb begin
      rext = dmem.dmem_rdata;
      unique case (sz_q)
         SZ_B:    rext = {{24{rbyte[7] & ~uns_q}}, rbyte};
         SZ_H:    rext = {{16{rhalf[15] & ~uns_q}}, rhalf};
         default: rext = dmem.dmem_rdata;
      endcase
   end

   assign tmo = (cnt == CW'(RSP_TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: begin
            if (access) state_n = misal ? DONE : REQ;
         end
         REQ: begin
            if (dmem.dmem_gnt) state_n = WAIT_RSP;
         end
         WAIT_RSP: begin
            if (dmem.dmem_rvalid || tmo) state_n = DONE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign lsu_stall = ((state == IDLE) & access)
                    | (state == REQ)
                    | (state == WAIT_RSP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dmem.dmem_req   <= 1'b0;
         dmem.dmem_we    <= 1'b0;
         dmem.dmem_addr  <= '0;
         dmem.dmem_be    <= '0;
         dmem.dmem_wdata <= '0;
         lsu_done        <= 1'b0;
         lsu_misalign    <= 1'b0;
         lsu_bus_err     <= 1'b0;
         load_data       <= '0;
         off_q           <= '0;
         sz_q            <= SZ_W;
         uns_q           <= 1'b0;
         ld_q            <= 1'b0;
         cnt             <= '0;
      end else begin
         dmem.dmem_req <= (state_n == REQ);
         lsu_done      <= (state_n == DONE);
         lsu_misalign  <= (state == IDLE) & access & misal;
         lsu_bus_err   <= (state == WAIT_RSP)
                        & ~dmem.dmem_rvalid & tmo;
         if (state == IDLE && access) begin
            dmem.dmem_we    <= mem_write;
            dmem.dmem_addr  <= {mem_addr[31:2], 2'b00};
            dmem.dmem_be    <= be_st;
            dmem.dmem_wdata <= wd_st;
            off_q           <= mem_addr[1:0];
            sz_q            <= sz;
            uns_q           <= uns;
            ld_q            <= ~mem_write;
         end
         if (state == REQ) cnt <= '0;
         else if (state == WAIT_RSP) cnt <= cnt + 1'b1;
         // A timed-out load reports zero rather than stale data.
         if (state == WAIT_RSP && ld_q) begin
            if (dmem.dmem_rvalid) load_data <= rext;
            else if (tmo)         load_data <= '0;
         end
      end
   end

endmodule
